// File: rtl/soc_pkg.sv
// Shared constants and types for the SoC memory path.
// Holds the memory geometry, the arbiter FSM state type and the
// requester index assignments used by mem_arbiter and its testbench.
package soc_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int MEM_DEPTH      = 64;
    localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH);
    localparam int TIMEOUT_CYCLES = 16;

    // Requester slots on the arbiter's packed request vectors.
    localparam int REQ_IFETCH = 0;
    localparam int REQ_DATA   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage : soc_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
//   req_valid_i  : request bits of requester 0 and 1
//   last_grant_i : index of the requester granted most recently
//   grant_o      : one-hot grant (all zero when nobody requests)
// Purely combinational; the caller owns the last_grant register.
module rr_arbiter2 (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // NOTE: every output of an always_comb block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // Contention: the requester that did not win last time goes now.
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule : rr_arbiter2

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the instruction-fetch port
// (requester 0) and the load/store port (requester 1). One transaction is in
// flight at a time: accept in IDLE, issue a one-cycle memory request, wait for
// mem_valid_data (or a watchdog timeout), then pulse a one-cycle response.
//   clk, reset      : clock, asynchronous active-low reset
//   req_*           : packed per-requester request channel, slot r at [r*W +: W]
//   req_ready       : one-hot accept pulse (combinational, IDLE only)
//   rsp_valid/rdata/err : registered one-hot response, data and timeout flag
//   mem_*           : request/response interface to the memory
module mem_arbiter #(
    parameter int  DATA_WIDTH     = soc_pkg::DATA_WIDTH,
    parameter int  MEM_DEPTH      = soc_pkg::MEM_DEPTH,
    parameter int  TIMEOUT_CYCLES = soc_pkg::TIMEOUT_CYCLES,
    localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_req_valid,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_valid_data
);

    import soc_pkg::*;

    // Last counter value at which WAIT still waits; ISSUE is wait cycle 1,
    // so the response is forced after TIMEOUT_CYCLES cycles of silence.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [1:0]              grant;
    logic                    last_grant_q;
    logic                    gnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [7:0]              cnt_q;
    logic [1:0]              rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    accept;
    logic                    complete;
    logic                    timeout_hit;

    rr_arbiter2 u_rr (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|grant) state_d = ISSUE;
            ISSUE:   state_d = mem_valid_data ? IDLE : WAIT;
            WAIT:    if (mem_valid_data || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / decode logic. req_ready is gated by reset so a requester held
    // valid through reset never sees an accept while the arbiter is held.
    always_comb begin
        req_ready     = 2'b00;
        accept        = 1'b0;
        mem_req_valid = 1'b0;
        complete      = 1'b0;
        timeout_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = reset ? grant : 2'b00;
                accept    = reset && (|grant);
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                complete      = mem_valid_data;
            end
            WAIT: begin
                complete    = mem_valid_data;
                timeout_hit = !mem_valid_data && (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    // Transaction latches, watchdog counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;

            if (accept) begin
                gnt_q        <= grant[REQ_DATA];
                last_grant_q <= grant[REQ_DATA];
                we_q         <= req_we[grant[REQ_DATA]];
                addr_q       <= req_addr[grant[REQ_DATA]*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q      <= req_wdata[grant[REQ_DATA]*DATA_WIDTH +: DATA_WIDTH];
            end

            case (state_q)
                ISSUE:   cnt_q <= 8'd1;
                WAIT:    cnt_q <= cnt_q + 8'd1;
                default: cnt_q <= '0;
            endcase

            if (complete) begin
                rsp_valid_q <= {gnt_q, ~gnt_q};
                rsp_rdata_q <= we_q ? '0 : mem_rdata;
                rsp_err_q   <= 1'b0;
            end else if (timeout_hit) begin
                rsp_valid_q <= {gnt_q, ~gnt_q};
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    // Address/data stay on the bus after completion; only the write enable
    // is withdrawn once the transaction is over.
    assign mem_we    = we_q && (state_q != IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule : mem_arbiter
